// File: rtl/imem_loader_pkg.sv
//------------------------------------------------------------------------------
// Module      : imem_loader_pkg
// Description : Shared types for the instruction-memory boot loader.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [1:0] lane_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
//------------------------------------------------------------------------------
// Module      : byte_packer
// Description : Packs four stream bytes into a little-endian 32-bit word.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic [7:0]  i_byte,
    input  logic        i_clear,
    output logic [31:0] o_word,
    output logic        o_full
);

    localparam lane_t c_last_lane = lane_t'(BYTES_PER_WORD - 1);

    lane_t       r_lane;
    logic [31:0] r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_lane <= '0;
        end else if (i_push) begin
            r_lane <= r_lane + 2'd1;
            r_word <= {i_byte, r_word[31:8]};
        end
    end

    // Word as it stands once the current byte lands, so the consumer can
    // capture it on the same edge that accepts the final lane.
    assign o_word = {i_byte, r_word[31:8]};
    assign o_full = i_push && !i_clear && (r_lane == c_last_lane);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
//------------------------------------------------------------------------------
// Module      : imem_loader
// Description : Boot-time loader writing a length-prefixed byte image into
//               instruction memory, holding the core until complete.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_A,
    output logic [31:0]              mem_WD,
    output logic                     run,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   words_written
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t            r_state;
    state_t            w_next;
    logic              w_rdy;
    logic              w_push;
    logic              w_clear;
    logic              w_full;
    logic [31:0]       w_word;
    logic              w_hdr_zero;
    logic              w_hdr_big;
    logic [CW-1:0]     r_n;
    logic [CW-1:0]     r_idx;
    logic [31:0]       r_wd;
    logic [ADDR_W-1:0] r_a;

    assign w_push     = in_valid && in_ready;
    assign w_clear    = (r_state != HDR) && (r_state != DATA);
    assign w_hdr_zero = (w_word == 32'd0);
    assign w_hdr_big  = (w_word > 32'(DEPTH));

    byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_byte  (in_data),
        .i_clear (w_clear),
        .o_word  (w_word),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HDR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_rdy  = 1'b0;
        case (r_state)
            HDR: begin
                w_rdy = 1'b1;
                if (w_full) begin
                    if (w_hdr_zero)     w_next = DONE;
                    else if (w_hdr_big) w_next = ERR;
                    else                w_next = DATA;
                end
            end
            DATA: begin
                w_rdy = 1'b1;
                if (w_full) w_next = WRITE;
            end
            WRITE: begin
                if (r_idx + CW'(1) == r_n) w_next = DONE;
                else                       w_next = DATA;
            end
            DONE:    w_next = DONE;
            ERR:     w_next = ERR;
            default: w_next = HDR;
        endcase
    end

    // Refuse bytes during the reset cycle regardless of the pre-reset state.
    assign in_ready = w_rdy && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n   <= '0;
            r_idx <= '0;
            r_wd  <= '0;
            r_a   <= '0;
        end else begin
            // Only consumed when the header passed the DEPTH bound.
            if (r_state == HDR && w_full) begin
                r_n <= w_word[CW-1:0];
            end
            if (r_state == DATA && w_full) begin
                r_wd <= w_word;
                r_a  <= ADDR_W'({r_idx, 2'b00});
            end
            if (r_state == WRITE) begin
                r_idx <= r_idx + CW'(1);
            end
        end
    end

    assign mem_we        = (r_state == WRITE);
    assign mem_A         = r_a;
    assign mem_WD        = r_wd;
    assign run           = (r_state == DONE);
    assign err           = (r_state == ERR);
    assign words_written = r_idx;

endmodule

`default_nettype wire
